// File: rtl/spike_rate_encoder.sv
// Rate encoder: turns one frame of NUM_CH intensities into T_WIN timesteps of spikes.
// Default build compares against a shared Galois LFSR; define RATE_ACC_EN for deterministic phase accumulators.
module spike_rate_encoder #(
   parameter int          NUM_CH    = 8,
   parameter int          DATA_W    = 8,
   parameter int          T_WIN     = 16,
   parameter int          STEP_DIV  = 1,
   parameter logic [15:0] LFSR_SEED = 16'hACE1
) (
   input  logic                     clk,
   input  logic                     reset_n,
   input  logic                     in_valid,
   output logic                     in_ready,
   input  logic [NUM_CH*DATA_W-1:0] in_data,
   input  logic                     abort,
   output logic [NUM_CH-1:0]        spike_out,
   output logic                     spike_valid,
   output logic                     frame_done,
   output logic                     busy
);

   localparam int STEP_W = $clog2(T_WIN + 1);
   localparam int DIV_W  = $clog2(STEP_DIV) + 1;
   localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(T_WIN - 1);
   localparam logic [DIV_W-1:0]  DIV_LAST  = DIV_W'(STEP_DIV - 1);

   typedef enum logic {
      S_IDLE = 1'b0,
      S_RUN  = 1'b1
   } state_t;

   state_t              r_state;
   state_t              w_state_next;
   logic [STEP_W-1:0]   r_step;
   logic [DIV_W-1:0]    r_div;
   logic [NUM_CH-1:0]   r_spike;
   logic                r_valid;
   logic                r_done;
   logic [NUM_CH-1:0]   w_spike;
   logic                w_accept;
   logic                w_abort_run;
   logic                w_tick;
   logic                w_last;

   assign in_ready    = (r_state == S_IDLE) && !abort;
   assign busy        = (r_state == S_RUN);
   assign w_accept    = in_valid && in_ready;
   assign w_abort_run = (r_state == S_RUN) && abort;
   // A timestep fires when the divider wraps; abort suppresses the one that is due.
   assign w_tick      = (r_state == S_RUN) && !abort && (r_div == DIV_LAST);
   assign w_last      = w_tick && (r_step == LAST_STEP);

   assign spike_out   = r_spike;
   assign spike_valid = r_valid;
   assign frame_done  = r_done;

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:  if (w_accept) w_state_next = S_RUN;
         S_RUN:   if (abort || w_last) w_state_next = S_IDLE;
         default: w_state_next = S_IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         r_state <= S_IDLE;
         r_step  <= '0;
         r_div   <= '0;
         r_spike <= '0;
         r_valid <= 1'b0;
         r_done  <= 1'b0;
      end else begin
         r_state <= w_state_next;
         r_valid <= w_tick;
         r_done  <= w_last;
         r_spike <= w_tick ? w_spike : '0;
         if (w_accept || w_abort_run) begin
            r_div  <= '0;
            r_step <= '0;
         end else if (r_state == S_RUN) begin
            if (w_tick) begin
               r_div  <= '0;
               r_step <= r_step + 1'b1;
            end else begin
               r_div  <= r_div + 1'b1;
            end
         end
      end
   end

`ifdef RATE_ACC_EN
   // Each channel carries out of an 8-bit phase accumulator; the carry is the spike.
   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] r_int;
      logic [7:0] r_acc;
      logic [8:0] w_sum;

      assign w_sum       = {1'b0, r_acc} + {1'b0, r_int};
      assign w_spike[gi] = w_sum[8];

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n) begin
            r_int <= '0;
            r_acc <= '0;
         end else begin
            if (w_accept) r_int <= in_data[gi*DATA_W +: 8];
            if (w_accept || w_abort_run) r_acc <= '0;
            else if (w_tick)             r_acc <= w_sum[7:0];
         end
      end
   end
`else
   logic [15:0] r_lfsr;

   // Advances only on emitted timesteps, after the compare; never reseeded by a frame.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n)    r_lfsr <= LFSR_SEED;
      else if (w_tick) r_lfsr <= {1'b0, r_lfsr[15:1]} ^ (r_lfsr[0] ? 16'hB400 : 16'h0000);
   end

   for (genvar gi = 0; gi < NUM_CH; gi++) begin : g_ch
      logic [7:0] r_int;
      logic [7:0] w_rnd;

      assign w_rnd       = 8'({r_lfsr, r_lfsr} >> (2 * gi));
      assign w_spike[gi] = (r_int != 8'd0) && (r_int >= w_rnd);

      always_ff @(posedge clk or negedge reset_n) begin
         if (!reset_n)      r_int <= '0;
         else if (w_accept) r_int <= in_data[gi*DATA_W +: 8];
      end
   end
`endif

endmodule

// File: doc/spike_rate_encoder.md
Name: spike_rate_encoder

Overview:
- Converts one frame of NUM_CH unsigned pixel intensities into spike trains that drive the 8-bit input_spike bus of the first LIF layer.
- Runs for T_WIN timesteps per frame; the spike probability or rate of each channel is proportional to its intensity.
- Sits upstream of the first layer and accepts frames over a valid/ready handshake.

Parameters:
- NUM_CH, 8, number of channels; equals the spike bus width.
- DATA_W, 8, intensity width per channel; the comparison logic is fixed at 8 bits.
- T_WIN, 16, timesteps per frame; must be at least 1.
- STEP_DIV, 1, clk cycles per timestep; must be at least 1.
- LFSR_SEED, 16'hACE1, LFSR reset value; must be non-zero.

Ports:
- clk  in  1  clock.
- reset_n  in  1  reset, asynchronous, active-low.
- in_valid  in  1  frame available on in_data.
- in_ready  out  1  encoder can accept a frame.
- in_data  in  NUM_CH*DATA_W  intensities; channel i is at [i*8 +: 8].
- abort  in  1  synchronous frame cancel.
- spike_out  out  NUM_CH  spikes for the current timestep.
- spike_valid  out  1  one-cycle strobe per timestep.
- frame_done  out  1  one-cycle pulse; asserts together with the last spike_valid of a frame.
- busy  out  1  high while in RUN.

Behaviour:
- Clock and reset: clk is the only clock. reset_n is asynchronous and active-low.
- Reset values: state=IDLE, spike_out=0, spike_valid=0, frame_done=0, busy=0, step counter=0, divider=0, LFSR=LFSR_SEED, intensity registers=0, accumulators=0.
- in_ready is combinational: (state==IDLE) && !abort. It reads 1 after reset.
- FSM state IDLE:
  - A transfer occurs when in_valid && in_ready at a rising edge.
  - On transfer: latch all intensities, clear step counter, divider and accumulators, then go to RUN.
  - in_data is not sampled at any other time.
- FSM state RUN:
  - The divider counts 0..STEP_DIV-1.
  - When the divider wraps, a timestep is emitted: spike_out and spike_valid are registered and visible in the following cycle, and the step counter increments.
  - The first timestep is visible in the cycle after edge (accept + STEP_DIV). It is therefore visible one cycle after acceptance when STEP_DIV=1.
  - Outside spike_valid cycles, spike_out=0.
- End of frame: at the edge that emits timestep T_WIN, frame_done is registered high alongside spike_valid and state returns to IDLE. in_ready is high in that same cycle, so back-to-back frames have no gap when STEP_DIV=1.
- Backpressure: in_ready=0 in RUN, and in_valid is ignored.
- Abort:
  - When abort is sampled high in RUN, the next edge goes to IDLE and clears the divider and step counter.
  - The timestep due at that edge is suppressed: spike_valid=0 and frame_done=0.
  - abort in IDLE blocks acceptance that cycle and has no other effect.
- Spike rule, stochastic (default):
  - 16-bit Galois LFSR, mask 16'hB400.
  - rnd_i = (LFSR rotated right by 2*i)[7:0].
  - spike_i = (I_i != 0) && (I_i >= rnd_i). So I=0 never spikes and I=255 always spikes.
  - The LFSR advances once per emitted timestep, after the compare. It is not reseeded per frame, only by reset.
- Width rules:
  - Step counter is $clog2(T_WIN+1) bits.
  - Divider is $clog2(STEP_DIV)+1 bits.
  - No arithmetic overflow is possible in stochastic mode.

Optional Feature:
- Macro name: RATE_ACC_EN.
- When defined, the LFSR is removed and replaced by deterministic per-channel phase accumulators.
  - Each channel has a 9-bit accumulator: acc_i <= {1'b0, acc_i[7:0]} + I_i on each emitted timestep.
  - spike_i = the carry bit of that sum.
  - After t timesteps a channel has produced exactly floor(t*I_i/256) spikes.
  - Accumulators clear on frame accept and on abort.
- When undefined, stochastic mode applies and no accumulator registers exist.
- Handshake and timing are identical in both builds.

Test Plan:
- Reset: hold reset_n low for 3 cycles, then release -> all outputs 0 and in_ready=1; LFSR equals 16'hACE1 at the first compare.
- Default build, T_WIN=16, STEP_DIV=1, all intensities 0 -> 16 consecutive spike_valid pulses starting the cycle after accept, spike_out=8'h00 on each, frame_done on pulse 16, in_ready=1 that cycle.
- Default build, all intensities 8'hFF -> spike_out=8'hFF on all 16 pulses. Hold in_valid high throughout: in_ready=0 during RUN, and a second frame is accepted on the frame_done cycle.
- RATE_ACC_EN build, intensities ch0..ch3 = 128, 64, 255, 1, others 0 -> spike counts over 16 steps are 8, 4, 15, 0. ch0 spikes on steps 2, 4, ..., 16.
- STEP_DIV=4, T_WIN=16 -> spike_valid pulses spaced exactly 4 cycles apart; first pulse in the cycle after edge accept+4; frame_done coincides with the 16th pulse, 64 cycles after the first edge.
- Abort asserted after pulse 5 -> no further spike_valid, no frame_done, in_ready=1 the next cycle. A new frame of all 255 is then accepted and produces 16 pulses of 8'hFF.
